rtc_timekeeper: RTL
===================

Name: rtc_timekeeper

Overview:
- Parametrised time-of-day core: tick prescaler, seconds/minutes/hours counters, a validated time-set handshake, a minute-resolution alarm, 12/24-hour display mode and BCD outputs.
- Sits between the system clock and the segment display driver; its BCD outputs feed the display data mux directly.

Parameters:
- TICK_DIV, 65536, system clock cycles per second; must be >= 2.
- CNT_W, 17, prescaler width; must satisfy 2^CNT_W >= TICK_DIV.

Ports:
- clock  input  1  system clock
- reset  input  1  asynchronous, active-low reset
- run  input  1  1 = time advances; 0 = prescaler and time frozen
- mode12  input  1  1 = 12-hour display; 0 = 24-hour display
- set_valid  input  1  time-load request
- set_ready  output  1  core can accept a load this cycle
- set_hour  input  5  binary hour to load, legal 0..23
- set_min  input  6  binary minute to load, legal 0..59
- set_sec  input  6  binary second to load, legal 0..59
- set_err  output  1  one-cycle pulse: last load rejected
- alarm_en  input  1  alarm compare enable
- alarm_hour  input  5  binary alarm hour
- alarm_min  input  6  binary alarm minute
- alarm_hit  output  1  one-cycle alarm pulse
- sec_pulse  output  1  one-cycle pulse on every second tick
- hour_bcd  output  8  displayed hour, BCD (24h: 00..23; 12h: 01..12)
- min_bcd  output  8  minute, BCD 00..59
- sec_bcd  output  8  second, BCD 00..59
- pm  output  1  12h mode: 1 when internal hour >= 12; forced 0 in 24h mode

Behaviour:
- Reset (async assert, sync release):
  - prescaler = 0, time = 00:00:00.
  - set FSM in IDLE, so set_ready = 1.
  - set_err, alarm_hit, sec_pulse = 0.
  - hour_bcd = 0x00 in 24h mode, 0x12 in 12h mode.
- Prescaler:
  - When run = 1, counts 0..TICK_DIV-1 and wraps to 0.
  - Tick = (prescaler == TICK_DIV-1) && run. When run = 0, the prescaler holds its value.
- On a tick (registered; all effects visible the cycle after the tick condition):
  - sec increments; 59 wraps to 0 with a minute carry.
  - min increments on carry; 59 wraps to 0 with an hour carry.
  - hour increments on carry; 23 wraps to 0.
  - sec_pulse = 1 for the same cycle in which the new time appears.
- Set FSM has two states, IDLE and CHECK:
  - IDLE: set_ready = 1. On set_valid && set_ready, capture set_hour/set_min/set_sec into shadow registers and go to CHECK.
  - CHECK: set_ready = 0; lasts exactly one cycle, then returns to IDLE.
  - CHECK with all shadow fields legal: commit shadow to time, clear prescaler to 0, no set_err.
  - CHECK with any field out of range: time unchanged, set_err = 1 for one cycle, prescaler unaffected.
  - set_valid while set_ready = 0 is ignored; no queuing.
- Simultaneous events:
  - A tick in the CHECK cycle with a legal load: commit wins and the tick is discarded (no sec_pulse).
  - With an illegal load, the tick proceeds normally.
- Alarm:
  - alarm_hit = 1 for one cycle when a tick produces a time with sec == 0, min == alarm_min, hour == alarm_hour, and alarm_en = 1.
  - A set commit never raises alarm_hit, even when the loaded time matches.
  - Illegal alarm values never match.
- Display conversion (combinational from the time registers; no added latency):
  - 24h mode: hour_bcd = BCD(hour).
  - 12h mode: h12 = hour mod 12, with 0 shown as 12. Examples: 0 -> 0x12 with pm = 0; 12 -> 0x12 with pm = 1; 13 -> 0x01 with pm = 1.
  - min_bcd and sec_bcd are BCD of the binary counters.
- Reset mid-operation aborts CHECK; no commit and no set_err.

Test Plan (TICK_DIV = 4 for simulation):
- Reset then run = 1 for 4*60 cycles -> sec_pulse every 4th cycle; after 60 pulses min_bcd = 0x01, sec_bcd = 0x00.
- Load 23:59:58, then run 8 cycles -> sequence 23:59:59 then 00:00:00; hour_bcd = 0x00.
- Load 24:00:00 -> set_err pulses once; time unchanged. Also drive set_valid during CHECK -> ignored, set_ready = 0 for exactly 1 cycle.
- alarm_en = 1, alarm 07:30; load 07:29:58 and run -> alarm_hit single pulse at 07:30:00. Loading 07:30:00 directly -> no alarm_hit.
- mode12 = 1 with hours 0, 11, 12, 13, 23 -> hour_bcd/pm = 0x12/0, 0x11/0, 0x12/1, 0x01/1, 0x11/1.
- Legal load committing in the same cycle a tick is due -> loaded value held with no sec_pulse that cycle; next tick arrives TICK_DIV cycles later. Also run = 0 for 10 cycles -> time and prescaler frozen.

Source files
------------

// File: rtl/rtc_timekeeper_if.sv
// Bus bundle for rtc_timekeeper: run/mode controls, time-set handshake,
// alarm settings and the BCD display outputs.
interface rtc_timekeeper_if;
    logic       run;
    logic       mode12;
    // Time-set handshake: a load is accepted on a cycle where set_valid and
    // set_ready are both 1; set_valid while set_ready is 0 is dropped.
    logic       set_valid;
    logic       set_ready;
    logic [4:0] set_hour;
    logic [5:0] set_min;
    logic [5:0] set_sec;
    logic       set_err;
    logic       alarm_en;
    logic [4:0] alarm_hour;
    logic [5:0] alarm_min;
    logic       alarm_hit;
    logic       sec_pulse;
    logic [7:0] hour_bcd;
    logic [7:0] min_bcd;
    logic [7:0] sec_bcd;
    logic       pm;
    logic       dbg_set_state;

    modport master (
        output run, mode12, set_valid, set_hour, set_min, set_sec,
               alarm_en, alarm_hour, alarm_min,
        input  set_ready, set_err, alarm_hit, sec_pulse,
               hour_bcd, min_bcd, sec_bcd, pm, dbg_set_state
    );

    modport slave (
        input  run, mode12, set_valid, set_hour, set_min, set_sec,
               alarm_en, alarm_hour, alarm_min,
        output set_ready, set_err, alarm_hit, sec_pulse,
               hour_bcd, min_bcd, sec_bcd, pm, dbg_set_state
    );
endinterface

// File: rtl/rtc_timekeeper.sv
// Time-of-day core: second prescaler, h/m/s counters, validated time load,
// minute-resolution alarm and 12/24-hour BCD display outputs.
module rtc_timekeeper #(
    parameter int TICK_DIV = 65536,
    parameter int CNT_W    = 17
) (
    input  logic                clock,
    input  logic                reset,
    rtc_timekeeper_if.slave     io_bus
);
    localparam logic [0:0]       ST_IDLE   = 1'b0;
    localparam logic [0:0]       ST_CHECK  = 1'b1;
    localparam logic [CNT_W-1:0] PRESC_TOP = CNT_W'(TICK_DIV - 1);
    localparam logic [CNT_W-1:0] PRESC_ONE = CNT_W'(1);

    logic [CNT_W-1:0] r_presc;
    logic [4:0]       r_hour;
    logic [5:0]       r_min;
    logic [5:0]       r_sec;
    logic [0:0]       r_state;
    logic [4:0]       r_sh_hour;
    logic [5:0]       r_sh_min;
    logic [5:0]       r_sh_sec;
    logic             r_set_err;
    logic             r_alarm_hit;
    logic             r_sec_pulse;

    logic       w_tick;
    logic       w_legal;
    logic       w_commit;
    logic       w_reject;
    logic       w_sec_wrap;
    logic       w_min_wrap;
    logic [5:0] w_nsec;
    logic [5:0] w_nmin;
    logic [4:0] w_nhour;
    logic       w_alarm_match;
    logic [4:0] w_h12;
    logic [4:0] w_hour_disp;

    function automatic logic [7:0] to_bcd(input logic [5:0] v);
        logic [5:0] t;
        logic [5:0] o;
        t = v / 6'd10;
        o = v - t * 6'd10;
        return {t[3:0], o[3:0]};
    endfunction

    assign w_tick   = io_bus.run && (r_presc == PRESC_TOP);
    assign w_legal  = (r_sh_hour < 5'd24) && (r_sh_min < 6'd60) && (r_sh_sec < 6'd60);
    assign w_commit = (r_state == ST_CHECK) && w_legal;
    assign w_reject = (r_state == ST_CHECK) && !w_legal;

    assign w_sec_wrap = (r_sec == 6'd59);
    assign w_min_wrap = w_sec_wrap && (r_min == 6'd59);
    assign w_nsec     = w_sec_wrap ? 6'd0 : r_sec + 6'd1;
    assign w_nmin     = !w_sec_wrap ? r_min : (w_min_wrap ? 6'd0 : r_min + 6'd1);
    assign w_nhour    = !w_min_wrap ? r_hour : ((r_hour == 5'd23) ? 5'd0 : r_hour + 5'd1);

    // Counters only ever hold legal values, so out-of-range alarm settings never match.
    assign w_alarm_match = io_bus.alarm_en && (w_nsec == 6'd0) &&
                           (w_nmin == io_bus.alarm_min) && (w_nhour == io_bus.alarm_hour);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_presc     <= '0;
            r_hour      <= '0;
            r_min       <= '0;
            r_sec       <= '0;
            r_set_err   <= 1'b0;
            r_alarm_hit <= 1'b0;
            r_sec_pulse <= 1'b0;
        end else begin
            r_set_err   <= w_reject;
            // A committing load swallows a coincident tick.
            r_sec_pulse <= w_tick && !w_commit;
            r_alarm_hit <= w_tick && !w_commit && w_alarm_match;
            if (w_commit) begin
                r_presc <= '0;
                r_hour  <= r_sh_hour;
                r_min   <= r_sh_min;
                r_sec   <= r_sh_sec;
            end else begin
                if (io_bus.run)
                    r_presc <= (r_presc == PRESC_TOP) ? '0 : r_presc + PRESC_ONE;
                if (w_tick) begin
                    r_hour <= w_nhour;
                    r_min  <= w_nmin;
                    r_sec  <= w_nsec;
                end
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state   <= ST_IDLE;
            r_sh_hour <= '0;
            r_sh_min  <= '0;
            r_sh_sec  <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (io_bus.set_valid) begin
                        r_sh_hour <= io_bus.set_hour;
                        r_sh_min  <= io_bus.set_min;
                        r_sh_sec  <= io_bus.set_sec;
                        r_state   <= ST_CHECK;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    always_comb begin
        w_h12 = (r_hour >= 5'd12) ? r_hour - 5'd12 : r_hour;
        if (w_h12 == 5'd0)
            w_h12 = 5'd12;
        w_hour_disp = io_bus.mode12 ? w_h12 : r_hour;
    end

    assign io_bus.set_ready     = (r_state == ST_IDLE);
    assign io_bus.set_err       = r_set_err;
    assign io_bus.alarm_hit     = r_alarm_hit;
    assign io_bus.sec_pulse     = r_sec_pulse;
    assign io_bus.hour_bcd      = to_bcd({1'b0, w_hour_disp});
    assign io_bus.min_bcd       = to_bcd(r_min);
    assign io_bus.sec_bcd       = to_bcd(r_sec);
    assign io_bus.pm            = io_bus.mode12 && (r_hour >= 5'd12);
    assign io_bus.dbg_set_state = r_state[0];
endmodule
